huffman_bit_packer: RTL and testbench
=====================================

Name: huffman_bit_packer

Overview:
- Downstream consumer of the Huffman code generator.
- Latches the six code/mask pairs when code_valid pulses, then encodes a stream of gray symbols (1..6) into their variable-length codes, MSB-first.
- Packs the codes into bytes through a 16-bit bit accumulator.
- Valid/ready handshakes on both sides; byte-aligned flush on the last symbol.

Parameters:
- SYM_W, 8, width of the symbol input (matches gray_data).
- ACC_W, 16, bit accumulator width; must be at least 16.
- CNT_W, 16, width of the bit_total counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- code_valid  in  1  one-cycle pulse; HC1..HC6 and M1..M6 are valid.
- HC1..HC6  in  8 each  code for symbol k, LSB-aligned.
- M1..M6  in  8 each  mask for symbol k; contiguous ones from LSB; code length L = popcount(M).
- sym_valid  in  1  symbol offered.
- sym_data  in  SYM_W  symbol value.
- sym_last  in  1  qualifies the final symbol of a frame.
- sym_ready  out  1  symbol accepted when sym_valid && sym_ready.
- out_valid  out  1  packed byte available.
- out_data  out  8  packed byte; earliest bit in bit 7.
- out_ready  in  1  byte consumed when out_valid && out_ready.
- done  out  1  one-cycle pulse after the final padded byte is consumed.
- sym_err  out  1  sticky; an accepted symbol was outside 1..6.
- bit_total  out  CNT_W  code bits accepted in the current frame, excluding padding; saturates at all-ones.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State IDLE; table cleared.
  - acc=0, bit_cnt=0.
  - Outputs: sym_ready=0, out_valid=0, out_data=0, done=0, sym_err=0, bit_total=0.
- IDLE:
  - sym_ready=0.
  - On code_valid: latch the 12 inputs into the table, clear bit_total and sym_err, go to RUN.
- RUN:
  - sym_ready = (bit_cnt <= ACC_W-8).
  - On accept of symbol k in 1..6: append the L low bits of HCk, MSB first, below the bit_cnt bits already held; bit_cnt += L; bit_total += L.
  - L=0 (M=0) appends nothing.
  - Symbol 0 or >6: nothing appended, sym_err set, otherwise treated as a normal accept (including sym_last).
  - Accepting with sym_last=1: go to FLUSH.
  - code_valid in RUN or FLUSH is ignored.
- Byte move (any state except IDLE):
  - Condition: bit_cnt >= 8 (FLUSH: bit_cnt > 0) and (out_valid==0 or out_ready==1).
  - Action: top 8 held bits go to out_data, out_valid=1, bit_cnt -= 8, acc shifts.
  - In FLUSH with bit_cnt < 8, the byte is the held bits zero-padded at the LSB end and bit_cnt becomes 0.
- Same-cycle symbol accept and byte move: bit_cnt_next = bit_cnt + L - 8. The appended bits land after the remaining bits.
- out_valid && !out_ready: out_data holds stable; no move.
- FLUSH:
  - sym_ready=0.
  - When bit_cnt==0, out_valid==0 (or the last byte is consumed this cycle), and no move is pending: pulse done for one cycle and return to IDLE. A new code_valid is then required.
  - A frame ending exactly on a byte boundary gets no pad byte.
  - An empty frame produces no output bytes; done pulses after one cycle in FLUSH.
- Latencies:
  - Symbol accept to out_valid: next edge, if the byte completes and the output register is free.
  - Reset mid-frame discards all buffered bits.
- Widths: L ≤ 8; bit_cnt is 5 bits; acc is ACC_W. Max occupancy before accept is 8, so it never exceeds 16.

Decomposition:
- Package huffman_pkg:
  - NUM_SYM=6.
  - State encoding IDLE/RUN/FLUSH.
  - Byte width 8.
  - Code/mask width 8.
- Sub-module huffman_len_dec: combinational popcount of an 8-bit mask, giving a 4-bit length.
- Table mux and accumulator stay in the top.

Test Plan:
Code table for all tests: HC=1,1,0,3,4,5 and M=1,3,7,15,31,31 (codes 1, 01, 000, 0011, 00100, 00101).
1. Basic pack: symbols 1,2,3,1,1, then 2 with last, out_ready=1 -> bytes 0xA3, 0x40; done pulses; bit_total=10.
2. Flush pad: symbols 4 and 5 with last -> bytes 0x32, 0x00; done pulses once; bit_total=9.
3. Backpressure: out_ready=0, symbols streamed continuously -> out_data stays 0xA3; sym_ready drops once bit_cnt > 8; no bits lost after out_ready rises.
4. Bad symbol: symbol 7, then symbol 1 with last -> sym_err=1; byte 0x80; bit_total=1.
5. Reset mid-frame: reset low for 1 cycle with bits buffered -> all outputs 0, state IDLE; sym_ready stays 0 until a new code_valid.
6. Boundary: eight symbol 1s with last -> exactly one byte 0xFF; no pad byte; done pulses.

Source files
------------

// File: rtl/huffman_pkg.sv
// huffman_pkg: shared constants and state encoding for the Huffman bit packer.
package huffman_pkg;
  localparam int NUM_SYM = 6;
  localparam int IDX_W = $clog2(NUM_SYM);
  localparam int BYTE_W = 8;
  localparam int CODE_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
endpackage

// File: rtl/huffman_len_dec.sv
// huffman_len_dec: code length as the popcount of a contiguous-from-LSB mask.
module huffman_len_dec
  import huffman_pkg::*;
(
  input  logic [CODE_W-1:0] mask_i,
  output logic [3:0]        len_o
);
  always_comb begin
    len_o = '0;
    for (int i = 0; i < CODE_W; i++) len_o = len_o + {3'b0, mask_i[i]};
  end
endmodule

// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer: encodes symbols 1..6 through a latched code table and packs
// the variable-length codes MSB-first into bytes, flushing with zero pad at frame end.
module huffman_bit_packer
  import huffman_pkg::*;
#(
  parameter int SYM_W = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] HC1,
  input  logic [CODE_W-1:0] HC2,
  input  logic [CODE_W-1:0] HC3,
  input  logic [CODE_W-1:0] HC4,
  input  logic [CODE_W-1:0] HC5,
  input  logic [CODE_W-1:0] HC6,
  input  logic [CODE_W-1:0] M1,
  input  logic [CODE_W-1:0] M2,
  input  logic [CODE_W-1:0] M3,
  input  logic [CODE_W-1:0] M4,
  input  logic [CODE_W-1:0] M5,
  input  logic [CODE_W-1:0] M6,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym_data,
  input  logic              sym_last,
  output logic              sym_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  input  logic              out_ready,
  output logic              done,
  output logic              sym_err,
  output logic [CNT_W-1:0]  bit_total
);
  localparam int BC_W = $clog2(ACC_W + 1);

  state_e state_q, state_d;
  logic [CODE_W-1:0] hc_q [NUM_SYM];
  logic [CODE_W-1:0] m_q [NUM_SYM];
  logic [CODE_W-1:0] hc_in [NUM_SYM];
  logic [CODE_W-1:0] m_in [NUM_SYM];
  logic [ACC_W-1:0] acc_q, acc_d, acc_sh, code_bits;
  logic [BC_W-1:0] cnt_q, cnt_d, cnt_sh;
  logic [BC_W:0] sh;
  logic [3:0] len, add_len;
  logic [IDX_W-1:0] idx;
  logic sym_ok, accept, free, mv, fin;
  logic out_valid_q, done_q, sym_err_q;
  logic [BYTE_W-1:0] out_data_q;
  logic [CNT_W-1:0] bit_total_q, bit_total_d;
  logic [CNT_W:0] tot;

  assign hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
  assign m_in = '{M1, M2, M3, M4, M5, M6};
  assign sym_ok = sym_data != '0 && sym_data <= SYM_W'(NUM_SYM);
  assign idx = sym_ok ? IDX_W'(sym_data - SYM_W'(1)) : '0;

  huffman_len_dec u_len (.mask_i(m_q[idx]), .len_o(len));

  // Accumulator holds bit_cnt valid bits MSB-aligned; everything below them is zero.
  always_comb begin
    accept = sym_valid && sym_ready;
    free = !out_valid_q || out_ready;
    mv = free && ((state_q == RUN && cnt_q >= BC_W'(BYTE_W)) || (state_q == FLUSH && cnt_q != '0));
    acc_sh = mv ? acc_q << BYTE_W : acc_q;
    cnt_sh = !mv ? cnt_q : cnt_q >= BC_W'(BYTE_W) ? cnt_q - BC_W'(BYTE_W) : '0;
    add_len = accept && sym_ok ? len : 4'd0;
    code_bits = ACC_W'(hc_q[idx] & m_q[idx]);
    sh = (BC_W+1)'(ACC_W) - (BC_W+1)'(cnt_sh) - (BC_W+1)'(add_len);
    acc_d = add_len != 4'd0 ? acc_sh | (code_bits << sh) : acc_sh;
    cnt_d = cnt_sh + BC_W'(add_len);
    tot = (CNT_W+1)'(bit_total_q) + (CNT_W+1)'(add_len);
    bit_total_d = tot[CNT_W] ? '1 : tot[CNT_W-1:0];
    fin = state_q == FLUSH && cnt_q == '0 && free;
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = (state_q == IDLE && code_valid) ? RUN :
              (state_q == RUN && accept && sym_last) ? FLUSH :
              fin ? IDLE : state_q;
  end

  always_comb begin
    sym_ready = state_q == RUN && cnt_q <= BC_W'(ACC_W - BYTE_W);
    out_valid = out_valid_q;
    out_data = out_data_q;
    done = done_q;
    sym_err = sym_err_q;
    bit_total = bit_total_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hc_q <= '{default: '0};
      m_q <= '{default: '0};
      acc_q <= '0;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      done_q <= 1'b0;
      sym_err_q <= 1'b0;
      bit_total_q <= '0;
    end else begin
      if (state_q == IDLE && code_valid) begin
        hc_q <= hc_in;
        m_q <= m_in;
        bit_total_q <= '0;
        sym_err_q <= 1'b0;
      end else if (accept) begin
        bit_total_q <= bit_total_d;
        if (!sym_ok) sym_err_q <= 1'b1;
      end
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      out_valid_q <= mv || (out_valid_q && !out_ready);
      if (mv) out_data_q <= acc_q[ACC_W-1 -: BYTE_W];
      done_q <= fin;
    end
  end
endmodule

// File: tb/tb_huffman_bit_packer.sv
// tb_huffman_bit_packer: scoreboard bench; a bit-queue model predicts packed bytes.
module tb_huffman_bit_packer;
  logic clk = 1'b0, reset = 1'b0, code_valid = 1'b0;
  logic sym_valid = 1'b0, sym_last = 1'b0, out_ready = 1'b1;
  logic [7:0] sym_data = '0;
  logic [7:0] hc [6] = '{8'd1, 8'd1, 8'd0, 8'd3, 8'd4, 8'd5};
  logic [7:0] mk [6] = '{8'd1, 8'd3, 8'd7, 8'd15, 8'd31, 8'd31};
  logic sym_ready, out_valid, done, sym_err;
  logic [7:0] out_data;
  logic [15:0] bit_total;

  int checks = 0, errors = 0, done_cnt = 0, rd = 0, exp_total = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  bit bitq[$];

  huffman_bit_packer dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc[0]), .HC2(hc[1]), .HC3(hc[2]), .HC4(hc[3]), .HC5(hc[4]), .HC6(hc[5]),
    .M1(mk[0]), .M2(mk[1]), .M3(mk[2]), .M4(mk[3]), .M5(mk[4]), .M6(mk[5]),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last), .sym_ready(sym_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .done(done), .sym_err(sym_err), .bit_total(bit_total)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) got_q.push_back(out_data);
    if (done) done_cnt++;
  end

  task automatic model_push(input int k, input bit last);
    logic [7:0] b;
    if (k >= 1 && k <= 6) begin
      for (int i = $countones(mk[k-1]) - 1; i >= 0; i--) bitq.push_back(hc[k-1][i]);
      exp_total += $countones(mk[k-1]);
    end
    while (bitq.size() >= 8 || (last && bitq.size() > 0)) begin
      b = '0;
      for (int i = 0; i < 8; i++) b = {b[6:0], bitq.size() > 0 ? bitq.pop_front() : 1'b0};
      exp_q.push_back(b);
    end
  endtask

  task automatic load_table();
    code_valid = 1'b1;
    @(posedge clk); #1 code_valid = 1'b0;
    exp_total = 0;
    bitq.delete();
  endtask

  task automatic send_sym(input int k, input bit last);
    bit ok = 1'b0;
    sym_valid = 1'b1; sym_data = 8'(k); sym_last = last;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge clk);
      ok = sym_ready;
    end
    @(posedge clk); #1 sym_valid = 1'b0; sym_last = 1'b0;
    if (ok) model_push(k, last);
    else begin
      checks++; errors++;
      $display("FAIL send_timeout: sym %0d not accepted, sym_ready=%b", k, sym_ready);
    end
  endtask

  task automatic wait_done(input int start);
    int n = 0;
    while (done_cnt == start && n < 200) begin
      @(negedge clk); n++;
    end
    if (done_cnt == start) begin
      checks++; errors++;
      $display("FAIL done_timeout: done never pulsed, got %0d pulses need 1", done_cnt - start);
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({sym_ready, out_valid, out_data, done, sym_err, bit_total} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b/%b/%h/%b/%b/%h need all zero", sym_ready, out_valid, out_data, done, sym_err, bit_total);
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (sym_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b need 0", sym_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int ds = done_cnt, r0 = rd;
    out_ready = 1'b1;
    load_table();
    send_sym(1, 0); send_sym(2, 0); send_sym(3, 0); send_sym(1, 0); send_sym(1, 0); send_sym(2, 1);
    wait_done(ds);
    checks++;
    if (got_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d bytes need %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[0]) begin errors++; $display("FAIL basic_byte: got %h need %h", got_q[rd], exp_q[0]); end
      rd++; void'(exp_q.pop_front());
    end
    exp_q.delete(); rd = got_q.size();
    checks++;
    if (rd - r0 != 2 || got_q[r0] !== 8'hA3 || got_q[r0+1] !== 8'h40) begin errors++; $display("FAIL basic_const: got %0d bytes first %h need A3 40", rd - r0, got_q[r0]); end
    checks++;
    if (bit_total !== 16'd10) begin errors++; $display("FAIL basic_total: got %0d need 10", bit_total); end
    checks++;
    if (done_cnt - ds != 1) begin errors++; $display("FAIL basic_done: got %0d pulses need 1", done_cnt - ds); end
  endtask

  task automatic test_flush_pad();
    int ds = done_cnt, r0 = rd;
    load_table();
    send_sym(4, 0); send_sym(5, 1);
    wait_done(ds);
    checks++;
    if (got_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL pad_count: got %0d bytes need %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[0]) begin errors++; $display("FAIL pad_byte: got %h need %h", got_q[rd], exp_q[0]); end
      rd++; void'(exp_q.pop_front());
    end
    exp_q.delete(); rd = got_q.size();
    checks++;
    if (rd - r0 != 2 || got_q[r0] !== 8'h32 || got_q[r0+1] !== 8'h00) begin errors++; $display("FAIL pad_const: got %0d bytes first %h need 32 00", rd - r0, got_q[r0]); end
    checks++;
    if (bit_total !== 16'd9) begin errors++; $display("FAIL pad_total: got %0d need 9", bit_total); end
    checks++;
    if (done_cnt - ds != 1) begin errors++; $display("FAIL pad_done: got %0d pulses need 1", done_cnt - ds); end
  endtask

  task automatic test_backpressure();
    int ds = done_cnt;
    out_ready = 1'b0;
    load_table();
    send_sym(1, 0); send_sym(2, 0); send_sym(3, 0); send_sym(1, 0); send_sym(1, 0);
    send_sym(4, 0); send_sym(4, 0); send_sym(4, 0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA3 || sym_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall: got valid=%b data=%h ready=%b need 1 A3 0", out_valid, out_data, sym_ready);
    end
    @(posedge clk); #1;
    fork
      send_sym(2, 1);
      begin
        repeat (4) begin
          @(negedge clk);
          checks++;
          if (sym_ready !== 1'b0 || out_data !== 8'hA3) begin errors++; $display("FAIL bp_hold: got ready=%b data=%h need 0 A3", sym_ready, out_data); end
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_done(ds);
    checks++;
    if (got_q.size() - rd != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d bytes need %0d", got_q.size() - rd, exp_q.size()); end
    while (exp_q.size() > 0 && rd < got_q.size()) begin
      checks++;
      if (got_q[rd] !== exp_q[0]) begin errors++; $display("FAIL bp_byte: got %h need %h", got_q[rd], exp_q[0]); end
      rd++; void'(exp_q.pop_front());
    end
    exp_q.delete(); rd = got_q.size();
    checks++;
    if (bit_total !== 16'(exp_total)) begin errors++; $display("FAIL bp_total: got %0d need %0d", bit_total, exp_total); end
  endtask

  task automatic test_bad_symbol();
    int ds = done_cnt, r0 = rd;
    load_table();
    send_sym(7, 0);
    @(negedge clk);
    checks++;
    if (sym_err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b need 1", sym_err); end
    @(posedge clk); #1;
    send_sym(1, 1);
    wait_done(ds);
    checks++;
    if (got_q.size() - rd != 1 || got_q[r0] !== 8'h80) begin errors++; $display("FAIL bad_byte: got %0d bytes first %h need 1 byte 80", got_q.size() - rd, got_q[r0]); end
    exp_q.delete(); rd = got_q.size();
    checks++;
    if (bit_total !== 16'd1 || sym_err !== 1'b1) begin errors++; $display("FAIL bad_total: got total=%0d err=%b need 1 1", bit_total, sym_err); end
  endtask

  task automatic test_reset_mid();
    int ds = done_cnt;
    load_table();
    send_sym(1, 0); send_sym(1, 0); send_sym(1, 0);
    reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({sym_ready, out_valid, out_data, done, sym_err, bit_total} !== 28'd0) begin
      errors++;
      $display("FAIL rst_mid: got %b/%b/%h/%b/%b/%h need all zero", sym_ready, out_valid, out_data, done, sym_err, bit_total);
    end
    sym_valid = 1'b1; sym_data = 8'd1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (sym_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b need 0", sym_ready); end
    end
    sym_valid = 1'b0;
    checks++;
    if (got_q.size() != rd || done_cnt != ds) begin errors++; $display("FAIL rst_output: got %0d bytes %0d dones need 0 0", got_q.size() - rd, done_cnt - ds); end
    bitq.delete(); exp_q.delete(); rd = got_q.size();
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    int ds = done_cnt, r0 = rd;
    load_table();
    for (int i = 0; i < 8; i++) send_sym(1, i == 7);
    wait_done(ds);
    checks++;
    if (got_q.size() - rd != exp_q.size() || got_q.size() - rd != 1) begin errors++; $display("FAIL edge_count: got %0d bytes need 1", got_q.size() - rd); end
    checks++;
    if (got_q.size() > r0 && got_q[r0] !== 8'hFF) begin errors++; $display("FAIL edge_byte: got %h need FF", got_q[r0]); end
    exp_q.delete(); rd = got_q.size();
    checks++;
    if (done_cnt - ds != 1 || bit_total !== 16'd8) begin errors++; $display("FAIL edge_done: got %0d pulses total %0d need 1 8", done_cnt - ds, bit_total); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_flush_pad();
    test_backpressure();
    test_bad_symbol();
    test_reset_mid();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
